vga_timing_generator: RTL and testbench

//  Parametrised VGA raster timing generator with a pixel-request pipeline. Default timing is 640x480@60Hz.

---
 rtl/vga_timing_generator.sv | 146 ++++++++++++++
 tb/tb_vga_timing_generator.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_generator.sv
// vga_timing_generator: VGA raster counters, pixel requests and a two-stage sync/RGB pipeline; define VGA_TEST_PATTERN_EN to add testMode colour bars
module vga_timing_generator #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0,
  parameter int CLK_DIV    = 1,
  parameter int COLOR_BITS = 4,
  parameter int CW         = 10
) (
  input  logic                  clk,
  input  logic                  resetN,
`ifdef VGA_TEST_PATTERN_EN
  input  logic                  testMode,
`endif
  input  logic [COLOR_BITS-1:0] inRed,
  input  logic [COLOR_BITS-1:0] inGreen,
  input  logic [COLOR_BITS-1:0] inBlue,
  output logic                  pixelTick,
  output logic                  pixelReq,
  output logic [CW-1:0]         pixelX,
  output logic [CW-1:0]         pixelY,
  output logic                  lineStart,
  output logic                  frameStart,
  output logic                  hSync,
  output logic                  vSync,
  output logic [COLOR_BITS-1:0] outRed,
  output logic [COLOR_BITS-1:0] outGreen,
  output logic [COLOR_BITS-1:0] outBlue
);
  localparam logic [3:0]    DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CW-1:0] H_VIS    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_VIS    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_FIRST = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_FIRST = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [3:0]            div_q, div_d;
  logic [CW-1:0]         h_q, h_d, v_q, v_d;
  logic                  act1_q, act1_d, hs1_q, hs1_d, vs1_q, vs1_d;
  logic                  hsync_q, hsync_d, vsync_q, vsync_d;
  logic [COLOR_BITS-1:0] red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic [COLOR_BITS-1:0] src_r, src_g, src_b;
  logic                  h_wrap, active;

  // pixel divider, raster counters and the request strobes they imply
  always_comb begin
    pixelTick  = resetN && div_q == DIV_LAST;
    h_wrap     = h_q == H_LAST;
    active     = h_q < H_VIS && v_q < V_VIS;
    div_d      = pixelTick ? '0 : div_q + 4'd1;
    h_d        = pixelTick ? (h_wrap ? '0 : h_q + 1'b1) : h_q;
    v_d        = pixelTick && h_wrap ? (v_q == V_LAST ? '0 : v_q + 1'b1) : v_q;
    pixelReq   = pixelTick && active;
    pixelX     = h_q;
    pixelY     = v_q;
    lineStart  = pixelTick && h_q == '0;
    frameStart = lineStart && v_q == '0;
  end

`ifdef VGA_TEST_PATTERN_EN
  logic [CW-1:0] x1_q, x1_d;
  logic          tm1_q, tm1_d;
  logic [2:0]    bar;
  // colour bars replace the source colours for pixels requested while testMode was high
  always_comb begin
    x1_d  = pixelTick ? h_q : x1_q;
    tm1_d = pixelTick ? testMode : tm1_q;
    bar   = 3'(x1_q / CW'(H_ACTIVE / 8));
    src_r = tm1_q ? {COLOR_BITS{~bar[1]}} : inRed;
    src_g = tm1_q ? {COLOR_BITS{~bar[2]}} : inGreen;
    src_b = tm1_q ? {COLOR_BITS{~bar[0]}} : inBlue;
  end
  // stage1 copy of the column and mode so the bar matches the pixel in flight
  always_ff @(posedge clk)
    if (!resetN) begin
      x1_q  <= '0;
      tm1_q <= 1'b0;
    end else begin
      x1_q  <= x1_d;
      tm1_q <= tm1_d;
    end
`else
  // colours come straight from the source
  always_comb begin
    src_r = inRed;
    src_g = inGreen;
    src_b = inBlue;
  end
`endif

  // stage1 holds flags of the requested pixel, stage2 lines them up with the returned colour
  always_comb begin
    act1_d  = pixelTick ? active : act1_q;
    hs1_d   = pixelTick ? h_q >= HS_FIRST && h_q <= HS_LAST : hs1_q;
    vs1_d   = pixelTick ? v_q >= VS_FIRST && v_q <= VS_LAST : vs1_q;
    hsync_d = pixelTick ? (hs1_q ? H_SYNC_POL : ~H_SYNC_POL) : hsync_q;
    vsync_d = pixelTick ? (vs1_q ? V_SYNC_POL : ~V_SYNC_POL) : vsync_q;
    red_d   = pixelTick ? (act1_q ? src_r : '0) : red_q;
    green_d = pixelTick ? (act1_q ? src_g : '0) : green_q;
    blue_d  = pixelTick ? (act1_q ? src_b : '0) : blue_q;
  end

  // all state restarts from the top-left corner on reset
  always_ff @(posedge clk)
    if (!resetN) begin
      div_q   <= '0;
      h_q     <= '0;
      v_q     <= '0;
      act1_q  <= 1'b0;
      hs1_q   <= 1'b0;
      vs1_q   <= 1'b0;
      hsync_q <= ~H_SYNC_POL;
      vsync_q <= ~V_SYNC_POL;
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
    end else begin
      div_q   <= div_d;
      h_q     <= h_d;
      v_q     <= v_d;
      act1_q  <= act1_d;
      hs1_q   <= hs1_d;
      vs1_q   <= vs1_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
    end

  assign hSync    = hsync_q;
  assign vSync    = vsync_q;
  assign outRed   = red_q;
  assign outGreen = green_q;
  assign outBlue  = blue_q;
endmodule

// File: tb/tb_vga_timing_generator.sv
// tb_vga_timing_generator: two small-raster instances (CLK_DIV 1 and 3) checked every clock against an arithmetic raster model
module tb_vga_timing_generator;
  localparam int HA = 32, HF = 4, HS = 5, HB = 3, HT = HA + HF + HS + HB;
  localparam int VA = 6, VF = 2, VS = 2, VB = 3, VT = VA + VF + VS + VB;
  localparam int CB = 4, CW = 6, DA = 1, DB = 3;
  localparam logic [2:0] BAR_RGB [8] = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};

  typedef struct packed {
    logic          tick, req;
    logic [CW-1:0] x, y;
    logic          ls, fs, hs, vs;
    logic [CB-1:0] r, g, b;
  } obs_t;

  logic clk = 1'b0, resetN = 1'b0, test_mode = 1'b0;
  always #5 clk = ~clk;

  logic [CB-1:0] ra = '0, ga = '0, ba = '0, rb = '0, gb = '0, bb = '0;
  logic a_tick, a_req, a_ls, a_fs, a_hs, a_vs, b_tick, b_req, b_ls, b_fs, b_hs, b_vs;
  logic [CW-1:0] a_x, a_y, b_x, b_y;
  logic [CB-1:0] a_r, a_g, a_b, b_r, b_g, b_b;
  obs_t oa, ob;
  assign oa = {a_tick, a_req, a_x, a_y, a_ls, a_fs, a_hs, a_vs, a_r, a_g, a_b};
  assign ob = {b_tick, b_req, b_x, b_y, b_ls, b_fs, b_hs, b_vs, b_r, b_g, b_b};

  int checks = 0, failures = 0;
  int ka = 0, kb = 0;
  bit valid = 0;
  bit tma [8192];
  bit tmb [8192];

  vga_timing_generator #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .CLK_DIV(DA), .COLOR_BITS(CB), .CW(CW)
  ) dut_a (
    .clk(clk), .resetN(resetN),
`ifdef VGA_TEST_PATTERN_EN
    .testMode(test_mode),
`endif
    .inRed(ra), .inGreen(ga), .inBlue(ba),
    .pixelTick(a_tick), .pixelReq(a_req), .pixelX(a_x), .pixelY(a_y),
    .lineStart(a_ls), .frameStart(a_fs), .hSync(a_hs), .vSync(a_vs),
    .outRed(a_r), .outGreen(a_g), .outBlue(a_b)
  );

  vga_timing_generator #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .CLK_DIV(DB), .COLOR_BITS(CB), .CW(CW)
  ) dut_b (
    .clk(clk), .resetN(resetN),
`ifdef VGA_TEST_PATTERN_EN
    .testMode(test_mode),
`endif
    .inRed(rb), .inGreen(gb), .inBlue(bb),
    .pixelTick(b_tick), .pixelReq(b_req), .pixelX(b_x), .pixelY(b_y),
    .lineStart(b_ls), .frameStart(b_fs), .hSync(b_hs), .vSync(b_vs),
    .outRed(b_r), .outGreen(b_g), .outBlue(b_b)
  );

  function automatic logic [3*CB-1:0] colour(input int x, input int y);
    return {CB'(x), CB'(y), CB'(x ^ y)};
  endfunction

  // colour source: one-tick ROM-like latency, junk for non-visible requests
  always @(posedge clk) if (a_tick) {ra, ga, ba} <= a_req ? colour(int'(a_x), int'(a_y)) : (3*CB)'($urandom);
  always @(posedge clk) if (b_tick) {rb, gb, bb} <= b_req ? colour(int'(b_x), int'(b_y)) : (3*CB)'($urandom);

  // k = clocks with resetN high since the last reset; counters sit at tick k/d, pins show tick k/d-2
  function automatic obs_t expect_obs(input int k, input int d, input bit hp, input bit vp, input bit rstn, input bit tm);
    obs_t e;
    int t, h, v, q, qh, qv;
    logic [2:0] c;
    e = '0;
    t = k / d;
    h = t % HT;
    v = (t / HT) % VT;
    e.tick = rstn && (k % d == d - 1);
    e.req = e.tick && h < HA && v < VA;
    e.x = CW'(h);
    e.y = CW'(v);
    e.ls = e.tick && h == 0;
    e.fs = e.ls && v == 0;
    e.hs = ~hp;
    e.vs = ~vp;
    q = t - 2;
    if (q >= 0) begin
      qh = q % HT;
      qv = (q / HT) % VT;
      e.hs = (qh >= HA + HF && qh < HA + HF + HS) ? hp : ~hp;
      e.vs = (qv >= VA + VF && qv < VA + VF + VS) ? vp : ~vp;
      if (qh < HA && qv < VA) begin
        c = BAR_RGB[qh / (HA / 8)];
        {e.r, e.g, e.b} = tm ? {{CB{c[2]}}, {CB{c[1]}}, {CB{c[0]}}} : colour(qh, qv);
      end
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_inst(input string n, input obs_t o, input int k, input int d, input bit hp, input bit vp, input bit tm);
    obs_t e;
    e = expect_obs(k, d, hp, vp, resetN, tm);
    chk({n, "_tick"}, 32'(o.tick), 32'(e.tick));
    chk({n, "_req"}, 32'(o.req), 32'(e.req));
    if (e.req) begin
      chk({n, "_x"}, 32'(o.x), 32'(e.x));
      chk({n, "_y"}, 32'(o.y), 32'(e.y));
    end
    chk({n, "_lineStart"}, 32'(o.ls), 32'(e.ls));
    chk({n, "_frameStart"}, 32'(o.fs), 32'(e.fs));
    chk({n, "_hSync"}, 32'(o.hs), 32'(e.hs));
    chk({n, "_vSync"}, 32'(o.vs), 32'(e.vs));
    chk({n, "_red"}, 32'(o.r), 32'(e.r));
    chk({n, "_green"}, 32'(o.g), 32'(e.g));
    chk({n, "_blue"}, 32'(o.b), 32'(e.b));
  endtask

  // one clock: drive just after posedge, check at negedge, advance the model at the next posedge
  task automatic cycle(input bit rn, input bit tm);
    resetN = rn;
    test_mode = tm;
    @(negedge clk);
    if (valid) begin
      check_inst("a", oa, ka, DA, 1'b0, 1'b0, (ka / DA >= 2) ? tma[ka / DA - 2] : 1'b0);
      check_inst("b", ob, kb, DB, 1'b1, 1'b1, (kb / DB >= 2) ? tmb[kb / DB - 2] : 1'b0);
    end
    @(posedge clk);
    if (!resetN) begin
      ka = 0;
      kb = 0;
      valid = 1;
    end else begin
`ifdef VGA_TEST_PATTERN_EN
      if (ka % DA == DA - 1 && ka / DA < 8192) tma[ka / DA] = test_mode;
      if (kb % DB == DB - 1 && kb / DB < 8192) tmb[kb / DB] = test_mode;
`endif
      ka++;
      kb++;
    end
    #1;
  endtask

  initial begin
    bit tm, found;
    int rst_left;
    tm = 1'b0;
    found = 1'b0;
    rst_left = 0;
    @(posedge clk);
    #1;
    repeat (3) cycle(1'b0, tm);
    // free run: several frames for the fast instance, two for the divided one
    repeat (4000) begin
      if ($urandom_range(0, 39) == 0) tm = ~tm;
      cycle(1'b1, tm);
    end
    // mid-frame reset once instance a sits at (20,4)
    for (int i = 0; i < 1000 && !found; i++) begin
      if (ka % (HT * VT) == 4 * HT + 20) found = 1'b1;
      else cycle(1'b1, tm);
    end
    chk("wait_mid_frame", 32'(found), 32'd1);
    repeat (3) cycle(1'b0, tm);
    // random reset pulses and test-mode changes
    repeat (3000) begin
      if (rst_left == 0 && $urandom_range(0, 499) == 0) rst_left = $urandom_range(1, 4);
      if ($urandom_range(0, 39) == 0) tm = ~tm;
      cycle(rst_left == 0, tm);
      if (rst_left > 0) rst_left--;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
